copy_loop_sequencer: RTL and testbench
======================================

# copy_loop_sequencer

Controller that sequences an element-wise array copy, `y[i] = x[i]` for `i = 0 .. count-1`. It stands in for the generate-loop copy with a run-time loop. The block walks an index over a synchronous-read source array, buffers returned data, and writes it to a destination array under backpressure. It sits between a command source (start/count) and two single-port array wrappers.

## Interface
Parameters:
- `DEPTH`, default 10: number of array elements.
- `DATA_W`, default 32: element width.
- `ADDR_W`, default `$clog2(DEPTH)`: array address width.
- `CNT_W`, default `$clog2(DEPTH+1)`: count width.

Ports:
- `clk`  in  1  the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `count`  in  CNT_W  number of elements to copy; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted start until DONE.
- `done`  out  1  one-cycle completion pulse.
- `clamped`  out  1  one-cycle pulse, concurrent with `done`, when `count > DEPTH`.
- `src_rd_en`  out  1  source read strobe.
- `src_rd_addr`  out  ADDR_W  source index.
- `src_rd_data`  in  DATA_W  source data, valid exactly 1 cycle after `src_rd_en`.
- `dst_wr_en`  out  1  destination write valid; held until accepted.
- `dst_wr_addr`  out  ADDR_W  destination index.
- `dst_wr_data`  out  DATA_W  destination data.
- `dst_ready`  in  1  destination accepts the write when `dst_wr_en && dst_ready`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE.** On `start`:
  - Latch `n = min(count, DEPTH)`, clear `rd_idx` and `wr_idx`, and go to RUN.
  - If `n == 0`, go directly to DONE instead.
  - `start` in any other state is ignored.
- **RUN, read issue.** Assert `src_rd_en` with `src_rd_addr = rd_idx` iff both hold:
  - `rd_idx < n`, and
  - `occ + inflight - pop < 2`.
  - Here `occ` is the 2-entry skid FIFO occupancy, `inflight` is the read issued last cycle, and `pop = (occ != 0) && dst_ready`.
  - On issue, `rd_idx` increments.
- **RUN, data return.** Returned data is pushed into the FIFO together with its index. The FIFO never overflows.
- **RUN, write out.** The FIFO head drives `dst_wr_*`, with `dst_wr_en = (occ != 0)`.
  - On acceptance, pop the head and increment `wr_idx`.
  - When the accepted write has `wr_idx == n-1`, go to DONE.
- **DONE.** One cycle with `done = 1`, `busy = 0`, then IDLE.
- **Ordering.** Writes occur in strictly increasing index order. Each index in `0..n-1` is written exactly once.
- **Simultaneous events.**
  - Push and pop in the same cycle leaves `occ` unchanged.
  - Issue and pop in the same cycle is allowed when the issue condition holds.
- **Reset.** `rst` at any time, including mid-RUN, returns to IDLE and clears `occ`, `inflight`, both indices and `n`. Read data returning in the cycle after reset is discarded.
- **Reset values.** `busy`, `done`, `clamped`, `src_rd_en`, `dst_wr_en` are 0. `src_rd_addr`, `dst_wr_addr`, `dst_wr_data` are 0.

## Timing
- Start sampled in cycle 0.
  - First `src_rd_en` in cycle 1.
  - Data pushed at the end of cycle 2.
  - First `dst_wr_en` in cycle 3.
- With `dst_ready` held high:
  - One element per cycle.
  - Last write in cycle `n+2`.
  - `done` in cycle `n+3`.
  - Next start accepted in cycle `n+4`.
- With `n == 0`: `done` in cycle 1 and no array traffic.
- Backpressure: while `dst_wr_en && !dst_ready`, the `dst_wr_*` outputs stay stable. At most 2 reads are issued beyond the stalled head.

## Structure
- **Shared package** `copy_loop_pkg` holds:
  - the `state_e` enum (IDLE, RUN, DONE);
  - the FIFO entry struct `{addr, data}`;
  - the `SKID_DEPTH = 2` constant.
- **Sub-module** `copy_loop_skid_fifo`: 2-entry FIFO with push/pop, `occ`, and head outputs. All control (FSM, indices, issue logic) lives in the top module.

## Test plan
- **Unthrottled copy.** `count=10`, `dst_ready=1`, source `x[i]=i*3` → writes `(0,0)…(9,27)` in cycles 3..12; `done` in cycle 13; `busy` high in cycles 1..12.
- **Zero count.** `count=0` → `done` in cycle 1; no `src_rd_en` or `dst_wr_en`; `clamped=0`.
- **Clamping.** `count=15`, `DEPTH=10` → exactly 10 writes (indices 0..9); `clamped=1` with `done`.
- **Backpressure.** `count=4`, `dst_ready` low in cycles 3..6 → at most 2 reads beyond the head; `dst_wr_addr=0` stable during the stall; writes 0..3 in order; no drop or duplicate.
- **Reset mid-run.** `count=8`, `rst` pulsed in cycle 5 → all outputs 0 in cycle 6; late read data ignored. A new start with `count=2` copies exactly indices 0..1.
- **Start ignored while busy.** `count=3`, then `start` with `count=7` in cycle 2 → only 3 writes; single `done`.

Source files
------------

// File: rtl/copy_loop_pkg.sv
// Shared types and constants for the run-time copy-loop sequencer.
package copy_loop_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default-width FIFO entry; the top passes a same-shaped struct sized to its parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } skid_entry_t;

endpackage

// File: rtl/copy_loop_skid_fifo.sv
// Two-entry skid FIFO buffering returned source data with its index.
module copy_loop_skid_fifo
  import copy_loop_pkg::*;
#(
  parameter type entry_t = skid_entry_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output entry_t           head
);

  entry_t           mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [OCC_W-1:0] occ_q;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign occ  = occ_q;
  assign head = mem[rd_ptr];

endmodule

// File: rtl/copy_loop_sequencer.sv
// Run-time element copy y[i] = x[i]: issues source reads, buffers returns, writes under backpressure.
module copy_loop_sequencer
  import copy_loop_pkg::*;
#(
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              clamped,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [DATA_W-1:0] dst_wr_data,
  input  logic              dst_ready
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_start;
  logic [CNT_W-1:0]  rd_idx_q;
  logic [CNT_W-1:0]  wr_idx_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic              inflight_q;
  logic              clamped_q;
  logic              accept_start;
  logic              issue;
  logic              pop;
  logic              last_wr;
  logic [2:0]        level;
  logic [OCC_W-1:0]  occ;
  entry_t            head;
  entry_t            push_entry;

  assign n_start      = (count > DEPTH_C) ? DEPTH_C : count;
  assign accept_start = (state_q == IDLE) && start;

  // Projected FIFO level after this cycle's pop keeps the skid buffer from overflowing.
  assign pop     = (occ != '0) && dst_ready;
  assign level   = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign issue   = (state_q == RUN) && (rd_idx_q < n_q) && (level < 3'(SKID_DEPTH));
  assign last_wr = pop && (wr_idx_q == n_q - CNT_W'(1));

  assign push_entry = '{addr: inflight_addr_q, data: src_rd_data};

  copy_loop_skid_fifo #(
    .entry_t(entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_entry(push_entry),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_start == '0) ? DONE : RUN;
      RUN:     if (last_wr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Indices, latched length and the one-deep read-in-flight tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q             <= '0;
      rd_idx_q        <= '0;
      wr_idx_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      clamped_q       <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_addr_q <= ADDR_W'(rd_idx_q);
      if (accept_start) begin
        n_q       <= n_start;
        clamped_q <= (count > DEPTH_C);
        rd_idx_q  <= '0;
        wr_idx_q  <= '0;
      end else begin
        if (issue) rd_idx_q <= rd_idx_q + CNT_W'(1);
        if (pop)   wr_idx_q <= wr_idx_q + CNT_W'(1);
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign clamped     = (state_q == DONE) && clamped_q;
  assign src_rd_en   = issue;
  assign src_rd_addr = ADDR_W'(rd_idx_q);
  assign dst_wr_en   = (occ != '0);
  assign dst_wr_addr = head.addr;
  assign dst_wr_data = head.data;

endmodule

// File: tb/tb_copy_loop_sequencer.sv
// Directed self-checking bench for copy_loop_sequencer with a synchronous-read source model.
module tb_copy_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  count = '0;
  logic        busy, done, clamped;
  logic        src_rd_en;
  logic [3:0]  src_rd_addr;
  logic [31:0] src_rd_data = '0;
  logic        dst_wr_en;
  logic [3:0]  dst_wr_addr;
  logic [31:0] dst_wr_data;
  logic        dst_ready = 1'b1;

  logic [31:0] x [16];
  int pass_cnt = 0;
  int total_cnt = 0;

  copy_loop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .busy(busy), .done(done), .clamped(clamped),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (src_rd_en) src_rd_data <= x[src_rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sets start for the current cycle (cycle 0); returns positioned in cycle 1.
  task automatic do_start(input logic [3:0] cnt);
    start = 1'b1;
    count = cnt;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total_cnt++;
    if ({busy, done, clamped, src_rd_en, dst_wr_en} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, clamped, src_rd_en, dst_wr_en});
    else pass_cnt++;
    total_cnt++;
    if ({src_rd_addr, dst_wr_addr, dst_wr_data} !== 40'h0)
      $display("FAIL reset_data: got %h want 0", {src_rd_addr, dst_wr_addr, dst_wr_data});
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_unthrottled();
    int nw = 0, bad = 0, busy_err = 0, done_cyc = -1;
    dst_ready = 1'b1;
    do_start(4'd10);
    total_cnt++;
    if (src_rd_en !== 1'b1 || src_rd_addr !== 4'd0)
      $display("FAIL first_read: en=%b addr=%0d want en=1 addr=0", src_rd_en, src_rd_addr);
    else pass_cnt++;
    for (int c = 1; c <= 13; c++) begin
      if (busy !== (c <= 12)) busy_err++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (dst_wr_en && dst_ready) begin
        if (dst_wr_addr !== 4'(c - 3) || dst_wr_data !== 32'((c - 3) * 3)) bad++;
        nw++;
      end
      if (c == 13) begin
        total_cnt++;
        if (clamped !== 1'b0) $display("FAIL unthr_clamped: got %b want 0", clamped);
        else pass_cnt++;
      end
      if (c < 13) step();
    end
    total_cnt++;
    if (nw != 10) $display("FAIL unthr_writes: got %0d want 10", nw); else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL unthr_order: got %0d bad writes want 0", bad); else pass_cnt++;
    total_cnt++;
    if (busy_err != 0) $display("FAIL unthr_busy: got %0d bad cycles want 0", busy_err); else pass_cnt++;
    total_cnt++;
    if (done_cyc != 13) $display("FAIL unthr_done: got cycle %0d want 13", done_cyc); else pass_cnt++;
    step();
  endtask

  // Starts in cycle n+4 of the previous run, checking back-to-back acceptance too.
  task automatic test_zero();
    int traffic = 0;
    do_start(4'd0);
    total_cnt++;
    if ({done, clamped, busy} !== 3'b100)
      $display("FAIL zero_done: got done/clamped/busy=%b want 100", {done, clamped, busy});
    else pass_cnt++;
    for (int c = 1; c <= 3; c++) begin
      if (src_rd_en || dst_wr_en) traffic++;
      step();
    end
    total_cnt++;
    if (traffic != 0) $display("FAIL zero_traffic: got %0d cycles want 0", traffic); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL zero_single_done: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_clamp();
    int nw = 0, bad = 0, clamp_cyc = -1;
    dst_ready = 1'b1;
    do_start(4'd15);
    for (int c = 1; c <= 15; c++) begin
      if (clamped === 1'b1) begin
        if (clamp_cyc < 0 && done === 1'b1) clamp_cyc = c; else bad++;
      end
      if (dst_wr_en && dst_ready) begin
        if (dst_wr_addr !== 4'(nw) || dst_wr_data !== 32'(nw * 3)) bad++;
        nw++;
      end
      step();
    end
    total_cnt++;
    if (nw != 10) $display("FAIL clamp_writes: got %0d want 10", nw); else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL clamp_order: got %0d errors want 0", bad); else pass_cnt++;
    total_cnt++;
    if (clamp_cyc != 13) $display("FAIL clamp_pulse: got cycle %0d want 13", clamp_cyc); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int nw = 0, bad = 0, stall_err = 0, reads = 0, reads_at6 = -1, done_cyc = -1;
    dst_ready = 1'b1;
    do_start(4'd4);
    for (int c = 1; c <= 12; c++) begin
      dst_ready = !(c >= 3 && c <= 6);
      #1;
      if (src_rd_en) reads++;
      if (c == 6) reads_at6 = reads;
      if (c >= 3 && c <= 6 && (dst_wr_en !== 1'b1 || dst_wr_addr !== 4'd0 || dst_wr_data !== 32'd0))
        stall_err++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (dst_wr_en && dst_ready) begin
        if (dst_wr_addr !== 4'(nw) || dst_wr_data !== 32'(nw * 3)) bad++;
        nw++;
      end
      step();
    end
    dst_ready = 1'b1;
    total_cnt++;
    if (reads_at6 != 2) $display("FAIL bp_reads: got %0d reads by stall end want 2", reads_at6); else pass_cnt++;
    total_cnt++;
    if (stall_err != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err); else pass_cnt++;
    total_cnt++;
    if (nw != 4 || bad != 0) $display("FAIL bp_writes: got %0d writes %0d bad want 4/0", nw, bad); else pass_cnt++;
    total_cnt++;
    if (reads != 4) $display("FAIL bp_total_reads: got %0d want 4", reads); else pass_cnt++;
    total_cnt++;
    if (done_cyc != 11) $display("FAIL bp_done: got cycle %0d want 11", done_cyc); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    int nw = 0, bad = 0, done_cyc = -1;
    dst_ready = 1'b1;
    do_start(4'd8);
    for (int c = 1; c < 5; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, clamped, src_rd_en, dst_wr_en, src_rd_addr, dst_wr_addr, dst_wr_data} !== 45'h0)
      $display("FAIL midrst_outputs: got busy=%b done=%b rd=%b wr=%b raddr=%0d waddr=%0d wdata=%0d want all 0",
               busy, done, src_rd_en, dst_wr_en, src_rd_addr, dst_wr_addr, dst_wr_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (dst_wr_en !== 1'b0) $display("FAIL midrst_late_data: got wr_en=%b want 0", dst_wr_en); else pass_cnt++;
    do_start(4'd2);
    for (int c = 1; c <= 8; c++) begin
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (dst_wr_en && dst_ready) begin
        if (dst_wr_addr !== 4'(nw) || dst_wr_data !== 32'(nw * 3)) bad++;
        nw++;
      end
      step();
    end
    total_cnt++;
    if (nw != 2 || bad != 0) $display("FAIL midrst_rerun: got %0d writes %0d bad want 2/0", nw, bad); else pass_cnt++;
    total_cnt++;
    if (done_cyc != 5) $display("FAIL midrst_done: got cycle %0d want 5", done_cyc); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int nw = 0, bad = 0, dones = 0;
    dst_ready = 1'b1;
    do_start(4'd3);
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin start = 1'b1; count = 4'd7; end
      else start = 1'b0;
      if (done === 1'b1) dones++;
      if (dst_wr_en && dst_ready) begin
        if (dst_wr_addr !== 4'(nw) || dst_wr_data !== 32'(nw * 3)) bad++;
        nw++;
      end
      step();
    end
    start = 1'b0;
    total_cnt++;
    if (nw != 3 || bad != 0) $display("FAIL ignore_writes: got %0d writes %0d bad want 3/0", nw, bad); else pass_cnt++;
    total_cnt++;
    if (dones != 1) $display("FAIL ignore_done: got %0d done pulses want 1", dones); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) x[i] = 32'(i * 3);
    #1;
    test_reset();
    test_unthrottled();
    test_zero();
    test_clamp();
    test_backpressure();
    test_reset_midrun();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
